// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR stream cipher (encoder and decoder).
// Holds the default LFSR taps/seed and the single LFSR step function.
package xor_cipher_pkg;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'h00000001;
    localparam logic [31:0] ZERO_SUBST   = 32'h00000001;
    localparam int          WORD_W       = 32;

    // Galois LFSR, left-shifting: taps are applied when the MSB falls out.
    function automatic logic [31:0] lfsr_next(
        input logic [31:0] state,
        input logic [31:0] poly
    );
        return {state[30:0], 1'b0} ^ (state[31] ? poly : 32'h0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [31:0] seed_fix(input logic [31:0] seed);
        return (seed == 32'h0) ? ZERO_SUBST : seed;
    endfunction

endpackage

// File: rtl/xor_stream_decoder_if.sv
// Word stream bus around the decoder: ciphertext in, plaintext out.
// slave = decoder side, master = source/consumer side.
interface xor_stream_decoder_if;
    import xor_cipher_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/xor_stream_decoder_lfsr32_step.sv
// One combinational step of the 32-bit Galois keystream LFSR.
// Ports: state_i (current), poly_i (taps) -> next_o (advanced state).
module lfsr32_step
    import xor_cipher_pkg::*;
(
    input  logic [31:0] state_i,
    input  logic [31:0] poly_i,
    output logic [31:0] next_o
);

    assign next_o = lfsr_next(state_i, poly_i);

endmodule

// File: rtl/xor_stream_decoder.sv
// XOR stream cipher receiver: plaintext = ciphertext ^ LFSR keystream.
// Ports: clk, rst (async high), seed_load_i/seed_i (re-key),
// bus (slave: in/out valid-ready words), word_cnt_o (accepted words).
module xor_stream_decoder
    import xor_cipher_pkg::*;
#(
    parameter logic [31:0] POLY      = DEFAULT_POLY,
    parameter logic [31:0] INIT_SEED = DEFAULT_SEED,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seed_load_i,
    input  logic [31:0]          seed_i,
    xor_stream_decoder_if.slave  bus,
    output logic [CNT_W-1:0]     word_cnt_o
);

    logic [31:0]      lfsr_q, lfsr_d;
    logic [31:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      lfsr_step;
    logic             ready;
    logic             accept;

    lfsr32_step u_step (
        .state_i (lfsr_q),
        .poly_i  (POLY),
        .next_o  (lfsr_step)
    );

    // Output slot is free when empty or being drained this cycle.
    assign ready  = !rst && !seed_load_i && (!valid_q || bus.out_ready);
    assign accept = bus.in_valid && ready;

    always_comb begin
        lfsr_d  = lfsr_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (seed_load_i) begin
            // Held word belongs to the old key: drop it.
            lfsr_d  = seed_fix(seed_i);
            valid_d = 1'b0;
            cnt_d   = '0;
        end else if (accept) begin
            data_d  = bus.in_data ^ lfsr_q;
            valid_d = 1'b1;
            lfsr_d  = lfsr_step;
            cnt_d   = cnt_q + 1'b1;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q  <= INIT_SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign word_cnt_o    = cnt_q;

endmodule

// File: tb/tb_xor_stream_decoder.sv
// Self-checking bench for xor_stream_decoder: directed plan + random traffic
// against a keystream model indexed by words-since-seed.
module tb_xor_stream_decoder;
    import xor_cipher_pkg::*;

    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load_i = 1'b0;
    logic [31:0] seed_i = 32'h0;
    logic [15:0] word_cnt_o;

    xor_stream_decoder_if bus ();

    xor_stream_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .seed_load_i (seed_load_i),
        .seed_i      (seed_i),
        .bus         (bus.slave),
        .word_cnt_o  (word_cnt_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_seed;
    int          m_n;
    logic        m_valid;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Keystream word n after seed s: s * x^n mod P(x) over GF(2).
    function automatic logic [31:0] ks(input logic [31:0] s, input int n);
        logic [32:0] t;
        logic [31:0] r;
        r = s;
        for (int i = 0; i < n; i++) begin
            t = 33'(r) * 33'd2;
            r = t[31:0] ^ (t[32] ? POLY : 32'h0);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_seed  = 32'h1;
        m_n     = 0;
        m_valid = 1'b0;
        m_data  = 32'h0;
    endtask

    task automatic check_outs();
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", bus.out_data, m_data);
        check("word_cnt", 32'(word_cnt_o), 32'(16'(m_n)));
    endtask

    // Drive one cycle (called just after a falling edge), check outputs
    // at the following falling edge.
    task automatic cyc(input logic sl, input logic [31:0] sd,
                       input logic iv, input logic [31:0] id,
                       input logic ordy);
        logic rdy;
        seed_load_i   = sl;
        seed_i        = sd;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        #1;
        rdy = !sl && (!m_valid || ordy);
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        if (sl) begin
            m_seed  = (sd == 0) ? 32'h1 : sd;
            m_n     = 0;
            m_valid = 1'b0;
        end else if (iv && rdy) begin
            m_data  = id ^ ks(m_seed, m_n);
            m_n++;
            m_valid = 1'b1;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check_outs();
    endtask

    initial begin
        logic [31:0] held;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check_outs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'h1);
        @(negedge clk);

        // default seed, two zero words
        cyc(0, 0, 1, 32'h0, 1);
        check("ks0", bus.out_data, 32'h1);
        cyc(0, 0, 1, 32'h0, 1);
        check("ks1", bus.out_data, 32'h2);
        check("cnt2", 32'(word_cnt_o), 32'h2);
        cyc(0, 0, 0, 32'h0, 1);

        // seed with MSB set exercises the feedback taps
        cyc(1, 32'h80000000, 1, 32'h0, 1);
        cyc(0, 0, 1, 32'hFFFFFFFF, 1);
        check("seed_msb0", bus.out_data, 32'h7FFFFFFF);
        cyc(0, 0, 1, 32'h0, 1);
        check("seed_msb1", bus.out_data, 32'h04C11DB7);

        // zero seed substitution
        cyc(1, 32'h0, 1, 32'h0, 1);
        cyc(0, 0, 1, 32'h0, 1);
        check("seed_zero", bus.out_data, 32'h1);

        // backpressure then release without bubble
        cyc(0, 0, 1, 32'h12345678, 1);
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 32'hA5A5A5A5, 0);
            check("bp_stable", bus.out_data, held);
        end
        cyc(0, 0, 1, 32'hA5A5A5A5, 1);
        cyc(0, 0, 1, 32'h0F0F0F0F, 1);

        // re-key while a word is stalled
        cyc(0, 0, 1, 32'h11111111, 0);
        cyc(1, 32'hDEADBEEF, 1, 32'h0, 0);
        check("rekey_valid", 32'(bus.out_valid), 32'h0);
        check("rekey_cnt", 32'(word_cnt_o), 32'h0);

        // async reset mid-burst
        cyc(0, 0, 1, 32'h22222222, 1);
        cyc(0, 0, 1, 32'h33333333, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_cnt", 32'(word_cnt_o), 32'h0);
        check("arst_ready", 32'(bus.in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 1, 32'h0, 1);
        check("arst_lfsr", bus.out_data, 32'h1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic        sl;
            logic [31:0] sd;
            sl = ($urandom % 40) == 0;
            sd = (($urandom % 4) == 0) ? 32'h0 : $urandom;
            cyc(sl, sd, ($urandom % 4) != 0, $urandom,
                ($urandom % 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/xor_stream_decoder.md
Name: xor_stream_decoder

Overview:
- Receive side of the team's XOR stream cipher: recovers plaintext by XORing each 32-bit ciphertext word with a keystream word from a 32-bit Galois LFSR.
- The LFSR sequence matches the encoder side word for word when both ends are loaded with the same seed.
- Sits between a valid/ready word source (bus or serial deframer) and a downstream consumer.
- One registered output stage gives full throughput with backpressure.

Parameters:
- POLY, 32'h04C11DB7, LFSR feedback taps (Galois, left-shifting).
- INIT_SEED, 32'h00000001, LFSR state after reset; must be nonzero.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seed_load  input  1  load seed into LFSR this cycle.
- seed  input  32  new LFSR seed; value 0 is replaced by 32'h00000001.
- in_valid  input  1  ciphertext word present.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  32  ciphertext word.
- out_valid  output  1  plaintext word present.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  32  plaintext word.
- word_cnt  output  CNT_W  words accepted since reset or last seed load.

Behaviour:
- Reset (async, rst=1), held while asserted:
  - lfsr=INIT_SEED, out_valid=0, out_data=0, word_cnt=0.
  - in_ready is 0 while rst=1.
- Keystream:
  - The current LFSR state is the keystream word for the next accepted input.
  - Advance rule: next = {lfsr[30:0],1'b0} ^ (lfsr[31] ? POLY : 0).
  - The LFSR advances only on an accepted input word; it never free-runs.
- Handshake:
  - in_ready = !seed_load && (!out_valid || out_ready). Combinational; no dependence on in_valid.
  - Accept = in_valid && in_ready.
  - On accept, next edge: out_data <= in_data ^ lfsr; out_valid <= 1; lfsr <= next; word_cnt <= word_cnt+1, wrapping modulo 2^CNT_W.
  - Latency is 1 cycle from accept to out_valid.
  - Throughput is one word per cycle when out_ready is held at 1.
  - Output drains when out_valid && out_ready && !accept: out_valid <= 0. out_data holds its last value.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Seed load (highest priority after reset):
  - seed_load=1 forces in_ready=0, so no accept that cycle.
  - Next edge: lfsr <= (seed==0 ? 32'h1 : seed), word_cnt <= 0, out_valid <= 0.
  - Any held output word is discarded, because it belongs to the old key.
- Simultaneous drain and accept: out_valid stays 1 and out_data updates. No bubble.
- Reset mid-stream: the held word is lost and the LFSR returns to INIT_SEED. The upstream side must re-key.
- Arithmetic: pure bitwise XOR on 32 bits. No carries. Counter width is CNT_W.

Decomposition:
- Shared package xor_cipher_pkg holds:
  - constant DEFAULT_POLY = 32'h04C11DB7.
  - constant DEFAULT_SEED = 32'h00000001.
  - function lfsr_next(state, poly).
  - The encoder uses the same package, so both ends share one definition.
- One combinational sub-module, lfsr32_step (state, poly -> next), instantiated once.
- Handshake register, counter and XOR stay in the top module.

Test Plan:
- Reset then idle → out_valid=0, word_cnt=0, in_ready=1 with out_ready=0.
- Default seed, in_data=0 for two consecutive accepts with out_ready=1 → out_data=32'h00000001 then 32'h00000002, each one cycle after its accept; word_cnt=2.
- seed_load with seed=32'h80000000, then in_data=32'hFFFFFFFF, then in_data=0 → out_data=32'h7FFFFFFF, then 32'h04C11DB7.
- seed_load with seed=0, then in_data=0 → out_data=32'h00000001 (zero seed substituted).
- Backpressure: out_ready=0 after one accept, in_valid held high → in_ready=0, out_data stable for 5 cycles. Raising out_ready → next word accepted the same cycle, no bubble, keystream continuous.
- seed_load asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, word_cnt=0. rst pulsed mid-burst → outputs clear immediately (async), lfsr back to 32'h00000001.
